ring_link_tx: RTL and testbench

Transmit end of a PtRingV1 point-to-point ring link. It drains a show-ahead two-register FIFO read port and drives registered flits onto the link. Flow control is credit-based: one credit per free slot in the downstream receive FIFO, returned by the receiver as single-cycle pulses. The block sits between a station's egress FIFO and the ring wire toward the next station.

---
 rtl/ring_link_tx.sv | 130 +++++++++++++
 tb/tb_ring_link_tx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_link_tx.sv
// ring_link_tx -- transmit end of a PtRingV1 point-to-point ring link.
//
// Drains a show-ahead FIFO read port and drives registered flits onto the
// ring wire toward the next station. Flow control is credit-based. There is
// one credit per free slot in the downstream receive FIFO, and the receiver
// returns credits as single-cycle pulses.
//
// Optional feature: define RING_TX_PARITY_EN to add oLinkPar. It is even
// parity (XOR) of the flit, registered alongside oLinkDat.
//
// Ports:
//   clk         clock, all logic on rising edge
//   rst         synchronous active-low reset (0 = reset)
//   iLinkUp     link enable from ring control; 0 halts new sends
//   iFifoEmpty  upstream FIFO empty flag
//   iFifoDat    upstream FIFO head data (show-ahead, valid when not empty)
//   oFifoRdEn   pop strobe to upstream FIFO (combinational)
//   oLinkVld    link flit valid (registered)
//   oLinkDat    link flit data (registered, holds on idle cycles)
//   iCrdRet     one-cycle credit-return pulse from downstream receiver
//   oCrdCnt     current credit count
//   oCrdOvf     sticky error: credit returned while already at CREDITS
//   oFlitCnt    flits sent, wraps at 2^16
//   oLinkPar    (RING_TX_PARITY_EN only) XOR of the flit bits
module ring_link_tx #(
    parameter int WIDTH = 8,
    parameter int CREDITS = 2,
    localparam int CW = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iLinkUp,
    input  logic             iFifoEmpty,
    input  logic [WIDTH-1:0] iFifoDat,
    output logic             oFifoRdEn,
    output logic             oLinkVld,
    output logic [WIDTH-1:0] oLinkDat,
    input  logic             iCrdRet,
    output logic [CW-1:0]    oCrdCnt,
    output logic             oCrdOvf,
    output logic [15:0]      oFlitCnt
`ifdef RING_TX_PARITY_EN
    ,
    output logic             oLinkPar
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    state_t        state;
    logic          send;
    logic          crd_ovf_ev;
    logic          crd_ret_ok;
    logic [CW-1:0] crd_nxt;

    // NOTE: every signal gets a value at the top of this block. If any
    // branch left one unassigned, the tool would infer a latch.
    always_comb begin
        // rst is folded in so the FIFO is never popped while in reset.
        send       = rst && (state == RUN) && !iFifoEmpty &&
                     (oCrdCnt != '0) && iLinkUp;
        // A return at full count is only legal if this cycle's send makes
        // room for it. Otherwise it is a protocol error and is dropped.
        crd_ovf_ev = iCrdRet && (oCrdCnt == CW'(CREDITS)) && !send;
        crd_ret_ok = iCrdRet && !crd_ovf_ev;
        crd_nxt    = oCrdCnt - CW'(send) + CW'(crd_ret_ok);
    end

    assign oFifoRdEn = send;

    // NOTE: all state here uses non-blocking assignment, so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            oLinkVld <= 1'b0;
            oLinkDat <= '0;
            oCrdCnt  <= CW'(CREDITS);
            oCrdOvf  <= 1'b0;
            oFlitCnt <= 16'd0;
`ifdef RING_TX_PARITY_EN
            oLinkPar <= 1'b0;
`endif
        end else begin
            oLinkVld <= send;
            if (send) begin
                oLinkDat <= iFifoDat;
`ifdef RING_TX_PARITY_EN
                oLinkPar <= ^iFifoDat;
`endif
                oFlitCnt <= oFlitCnt + 16'd1;
            end

            // Credits keep counting in IDLE. A link drop must not lose
            // track of buffer space still held downstream.
            oCrdCnt <= crd_nxt;
            if (crd_ovf_ev) begin
                oCrdOvf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (iLinkUp) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!iLinkUp) begin
                        state <= IDLE;
                    end else if ((crd_nxt == '0) && !iCrdRet) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (!iLinkUp) begin
                        state <= IDLE;
                    end else if (iCrdRet) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_link_tx.sv
// Testbench for ring_link_tx: models the upstream show-ahead FIFO and keeps
// a scoreboard of popped flits. Each flit must appear on the link exactly
// one cycle after its pop.
module tb_ring_link_tx;

    localparam int WIDTH = 8;
    localparam int CREDITS = 2;
    localparam int CW = $clog2(CREDITS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             iLinkUp;
    logic             iFifoEmpty;
    logic [WIDTH-1:0] iFifoDat;
    logic             oFifoRdEn;
    logic             oLinkVld;
    logic [WIDTH-1:0] oLinkDat;
    logic             iCrdRet;
    logic [CW-1:0]    oCrdCnt;
    logic             oCrdOvf;
    logic [15:0]      oFlitCnt;
`ifdef RING_TX_PARITY_EN
    logic             oLinkPar;
`endif

    ring_link_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .iLinkUp    (iLinkUp),
        .iFifoEmpty (iFifoEmpty),
        .iFifoDat   (iFifoDat),
        .oFifoRdEn  (oFifoRdEn),
        .oLinkVld   (oLinkVld),
        .oLinkDat   (oLinkDat),
        .iCrdRet    (iCrdRet),
        .oCrdCnt    (oCrdCnt),
        .oCrdOvf    (oCrdOvf),
        .oFlitCnt   (oFlitCnt)
`ifdef RING_TX_PARITY_EN
        ,
        .oLinkPar   (oLinkPar)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int link_cnt = 0;
    int last_link_cyc = -1;

    logic [WIDTH-1:0] fifo_q[$];   // upstream FIFO model
    logic [WIDTH-1:0] exp_q[$];    // scoreboard: popped, awaiting link
    logic [WIDTH-1:0] pop_log[$];
    int               pop_cyc[$];
    logic             s_rd;

    task automatic drive_fifo();
        iFifoEmpty = (fifo_q.size() == 0);
        iFifoDat   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // One clock cycle: sample at negedge, advance at posedge, update the
    // FIFO model #1 after the edge.
    task automatic step();
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        cyc++;
        s_rd = oFifoRdEn;
        n_checks++;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            if (oLinkVld !== 1'b1 || oLinkDat !== exp)
                $display("FAIL link_flit cyc=%0d got vld=%b dat=%h want vld=1 dat=%h",
                         cyc, oLinkVld, oLinkDat, exp);
            else
                n_pass++;
`ifdef RING_TX_PARITY_EN
            n_checks++;
            if (oLinkPar !== ^exp)
                $display("FAIL link_par got %b want %b", oLinkPar, ^exp);
            else
                n_pass++;
`endif
        end else begin
            if (oLinkVld !== 1'b0)
                $display("FAIL link_idle cyc=%0d got vld=%b want 0", cyc, oLinkVld);
            else
                n_pass++;
        end
        if (oLinkVld === 1'b1) begin
            link_cnt++;
            last_link_cyc = cyc;
        end
        if (s_rd === 1'b1) begin
            n_checks++;
            if (fifo_q.size() == 0) begin
                $display("FAIL pop_empty cyc=%0d got rd_en=1 want 0", cyc);
            end else begin
                n_pass++;
                exp_q.push_back(fifo_q[0]);
                pop_log.push_back(fifo_q[0]);
                pop_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (s_rd === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        iLinkUp = 1'b1;
        iCrdRet = 1'b0;
        fifo_q.push_back(8'hAA);
        drive_fifo();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (s_rd !== 1'b0) $display("FAIL reset_rd_en got %b want 0", s_rd);
            else n_pass++;
        end
        rst = 1'b1;
        iLinkUp = 1'b0;
        fifo_q.delete();
        drive_fifo();
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (s_rd !== 1'b0) $display("FAIL idle_rd_en got %b want 0", s_rd);
            else n_pass++;
        end
        n_checks++;
        if (oCrdCnt !== CW'(CREDITS) || oFlitCnt !== 16'd0 || oCrdOvf !== 1'b0)
            $display("FAIL reset_state got crd=%0d flit=%0d ovf=%b want crd=2 flit=0 ovf=0",
                     oCrdCnt, oFlitCnt, oCrdOvf);
        else n_pass++;
    endtask

    task automatic test_credit_stall();
        pop_log.delete();
        pop_cyc.delete();
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        drive_fifo();
        iLinkUp = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (pop_log.size() != 2 || pop_log[0] !== 8'h11 || pop_log[1] !== 8'h22)
            $display("FAIL stall_pops got n=%0d want 0x11,0x22", pop_log.size());
        else n_pass++;
        n_checks++;
        if (pop_cyc.size() != 2 || pop_cyc[1] != pop_cyc[0] + 1)
            $display("FAIL stall_b2b got pop cycles not consecutive want consecutive");
        else n_pass++;
        n_checks++;
        if (oCrdCnt !== '0 || fifo_q.size() != 1)
            $display("FAIL stall_credits got crd=%0d fifo=%0d want crd=0 fifo=1",
                     oCrdCnt, fifo_q.size());
        else n_pass++;
    endtask

    task automatic test_credit_return();
        int pulse_cyc;
        pop_log.delete();
        pop_cyc.delete();
        iCrdRet = 1'b1;
        step();
        pulse_cyc = cyc;
        iCrdRet = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (pop_log.size() != 1 || pop_log[0] !== 8'h33 || pop_cyc[0] != pulse_cyc + 1)
            $display("FAIL return_pop got n=%0d want single 0x33 one cycle after pulse",
                     pop_log.size());
        else n_pass++;
        n_checks++;
        if (oCrdCnt !== '0 || oFlitCnt !== 16'd3)
            $display("FAIL return_counts got crd=%0d flit=%0d want crd=0 flit=3",
                     oCrdCnt, oFlitCnt);
        else n_pass++;
    endtask

    task automatic test_send_with_return();
        iCrdRet = 1'b1;
        step();
        iCrdRet = 1'b0;
        step();
        n_checks++;
        if (oCrdCnt !== CW'(1)) $display("FAIL one_credit got %0d want 1", oCrdCnt);
        else n_pass++;
        fifo_q.push_back(8'h44);
        drive_fifo();
        iCrdRet = 1'b1;
        step();
        iCrdRet = 1'b0;
        n_checks++;
        if (s_rd !== 1'b1) $display("FAIL simul_pop got %b want 1", s_rd);
        else n_pass++;
        n_checks++;
        if (oCrdCnt !== CW'(1) || oCrdOvf !== 1'b0)
            $display("FAIL simul_credit got crd=%0d ovf=%b want crd=1 ovf=0", oCrdCnt, oCrdOvf);
        else n_pass++;
        step();
    endtask

    task automatic test_overflow();
        iCrdRet = 1'b1;
        step();
        iCrdRet = 1'b0;
        n_checks++;
        if (oCrdCnt !== CW'(2) || oCrdOvf !== 1'b0)
            $display("FAIL full_credit got crd=%0d ovf=%b want crd=2 ovf=0", oCrdCnt, oCrdOvf);
        else n_pass++;
        iCrdRet = 1'b1;
        step();
        iCrdRet = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (oCrdCnt !== CW'(2) || oCrdOvf !== 1'b1)
            $display("FAIL overflow got crd=%0d ovf=%b want crd=2 ovf=1", oCrdCnt, oCrdOvf);
        else n_pass++;
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_checks++;
        if (oCrdOvf !== 1'b0 || oFlitCnt !== 16'd0 || oCrdCnt !== CW'(2))
            $display("FAIL ovf_clear got ovf=%b flit=%0d crd=%0d want 0,0,2",
                     oCrdOvf, oFlitCnt, oCrdCnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back_drop();
        int drop_cyc = -1;
        int link0;
        pop_log.delete();
        step();                       // IDLE -> RUN
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'h50 + WIDTH'(i));
        drive_fifo();
        iCrdRet = 1'b1;
        link0 = link_cnt;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pop_log.size() == 5) begin
                iLinkUp = 1'b0;
                iCrdRet = 1'b0;
                drop_cyc = cyc + 1;
                break;
            end
        end
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (pop_log.size() != 5 || link_cnt - link0 != 5)
            $display("FAIL drop_count got pops=%0d flits=%0d want 5,5",
                     pop_log.size(), link_cnt - link0);
        else n_pass++;
        n_checks++;
        if (last_link_cyc != drop_cyc)
            $display("FAIL drop_last_flit got cyc=%0d want %0d", last_link_cyc, drop_cyc);
        else n_pass++;
        n_checks++;
        if (oFlitCnt !== 16'd5 || oCrdCnt !== CW'(2) || oCrdOvf !== 1'b0 || fifo_q.size() != 5)
            $display("FAIL drop_state got flit=%0d crd=%0d ovf=%b fifo=%0d want 5,2,0,5",
                     oFlitCnt, oCrdCnt, oCrdOvf, fifo_q.size());
        else n_pass++;
        fifo_q.delete();
        drive_fifo();
    endtask

    task automatic test_flit_wrap();
        int link0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        pop_log.delete();
        pop_cyc.delete();
        iLinkUp = 1'b1;
        step();
        for (int i = 0; i < 65537; i++) fifo_q.push_back(WIDTH'(i));
        drive_fifo();
        iCrdRet = 1'b1;
        link0 = link_cnt;
        for (int i = 0; i < 65600; i++) begin
            step();
            if (pop_log.size() == 65537) break;
        end
        iLinkUp = 1'b0;
        iCrdRet = 1'b0;
        step();
        step();
        n_checks++;
        if (pop_log.size() != 65537 || link_cnt - link0 != 65537)
            $display("FAIL wrap_sends got pops=%0d flits=%0d want 65537 (cycle budget)",
                     pop_log.size(), link_cnt - link0);
        else n_pass++;
        n_checks++;
        if (oFlitCnt !== 16'd1 || oCrdOvf !== 1'b0)
            $display("FAIL wrap_count got flit=%0d ovf=%b want flit=1 ovf=0", oFlitCnt, oCrdOvf);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        iLinkUp = 1'b0;
        iCrdRet = 1'b0;
        drive_fifo();
        @(posedge clk);
        #1;
        test_reset();
        test_credit_stall();
        test_credit_return();
        test_send_with_return();
        test_overflow();
        test_back_to_back_drop();
        test_flit_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
